matrix_mul_seq_ctrl: RTL
========================

Name: matrix_mul_seq_ctrl

Overview:
Multi-cycle sequencer for matrix multiplication of up to 5x5 by 5x5, 8-bit unsigned elements. It uses one shared 8x8 multiplier and a 16-bit accumulator instead of 125 parallel multipliers, stepping i/j/k with a start/busy/done handshake. Operand and result packing match the combinational matrix multiply unit, so the two are interchangeable behind the calculator's top-level operation select.

Parameters:
DIM_MAX, 5, max rows/cols per matrix; sizes index counters and packed buses
ELEM_W, 8, operand element width (unsigned)
ACC_W, 16, result element and accumulator width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  request; sampled only in IDLE
a_m  in  3  rows of A
a_n  in  3  cols of A
b_m  in  3  rows of B
b_n  in  3  cols of B
matrixA  in  200  A, element (i,k) at bits [(i*5+k)*8 +: 8]
matrixB  in  200  B, element (k,j) at bits [(k*5+j)*8 +: 8]
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at completion (success or error)
valid  out  1  level; result valid, held until next accepted start
mulError  out  1  level; dimension error, held until next accepted start
c_m  out  3  result rows (a_m on success, else 0)
c_n  out  3  result cols (b_n on success, else 0)
aMulB  out  400  C, element (i,j) at bits [(i*5+j)*16 +: 16]; unused elements 0

Behaviour:
- Reset (sync, active-high): state=IDLE. busy, done, valid, mulError=0. c_m, c_n=0. aMulB=0. Counters and accumulator=0. Reset overrides start in the same cycle. Reset mid-operation aborts with no done pulse.
- States: IDLE, CHECK, MAC, DONE.
- IDLE: start=1 at edge E0:
  - latch a_m, a_n, b_m, b_n, matrixA, matrixB into internal registers; inputs may change afterwards.
  - clear valid, mulError, c_m, c_n, aMulB.
  - go to CHECK.
- CHECK (one cycle): error if any dim is 0, any dim > 5, or a_n != b_m.
  - Error: mulError<=1, go to DONE.
  - Otherwise: i=j=k=0, acc=0, go to MAC.
- MAC (one product per cycle): sum = acc + A[i][k]*B[k][j], truncated to 16 bits (wraps mod 2^16).
  - If k < a_n-1: acc<=sum, k<=k+1.
  - Else: write sum to element (i,j), acc<=0, k<=0.
    - If j < b_n-1: j<=j+1.
    - Else if i < a_m-1: j<=0, i<=i+1.
    - Else: valid<=1, c_m<=a_m, c_n<=b_n, go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- Latency: N = a_m*b_n*a_n MAC cycles. done is high in the cycle after edge E(1+N), i.e. N+2 cycles after start is sampled. Error path: done 2 cycles after start.
- start while not IDLE (including DONE) is ignored, with no queuing.
- valid/mulError/aMulB/c_m/c_n are stable from done until the edge accepting the next start.
- valid and mulError are never both 1.

Decomposition:
- Package matrix_pkg:
  - constants DIM_MAX, ELEM_W, ACC_W, A_BUS_W=200, C_BUS_W=400
  - state enum (IDLE, CHECK, MAC, DONE)
  - index functions elem_a_lsb(r,c)=(r*5+c)*8 and elem_c_lsb(r,c)=(r*5+c)*16
- One sub-module, matrix_elem_mac:
  - 8x8 unsigned multiply plus 16-bit wrapping add of acc, combinational.
  - Shared by this block and reusable elsewhere.
- FSM, counters, and result register stay in matrix_mul_seq_ctrl.

Test Plan:
- 2x2*2x2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start 1 cycle -> done pulse 10 cycles after start. aMulB elements (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50, rest 0. c_m=2, c_n=2, valid=1, mulError=0.
- a_m=2, a_n=3, b_m=2, b_n=2 -> done 2 cycles after start. mulError=1, valid=0, aMulB=0, c_m=c_n=0. Repeat with a_m=0, and with b_n=6: same response.
- 5x5*5x5 all elements 255 -> done at 127 cycles. Every element = 325125 mod 65536 = 62981 (0xF605).
- 1x3*3x1, A=[1,2,3], B=[4,5,6] -> done at 5 cycles. Element (0,0)=32, c_m=1, c_n=1. Change matrixA one cycle after start: result unchanged.
- Pulse start again mid-MAC and during DONE -> ignored. A single done occurs with the first result. A new start in IDLE clears valid at the acceptance edge.
- Assert reset at the 4th MAC cycle -> next cycle busy=0, done never pulses, outputs 0. A subsequent start computes correctly.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and packed-bus index helpers for the
// sequential matrix multiply unit.
package matrix_pkg;

    localparam int DIM_MAX = 5;
    localparam int ELEM_W  = 8;
    localparam int ACC_W   = 16;
    localparam int DIM_W   = 3;
    localparam int A_BUS_W = DIM_MAX * DIM_MAX * ELEM_W;
    localparam int C_BUS_W = DIM_MAX * DIM_MAX * ACC_W;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        MAC,
        DONE
    } state_t;

    // Operand buses use a fixed 5-wide row stride regardless of the actual size.
    function automatic int elem_a_lsb(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
        return (int'(r) * DIM_MAX + int'(c)) * ELEM_W;
    endfunction

    function automatic int elem_c_lsb(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
        return (int'(r) * DIM_MAX + int'(c)) * ACC_W;
    endfunction

endpackage

// File: rtl/matrix_elem_mac.sv
// Combinational multiply-accumulate step: 8x8 unsigned product added to a
// 16-bit accumulator, wrapping modulo 2^16.
module matrix_elem_mac
    import matrix_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  sum
);

    assign sum = acc + ACC_W'(a) * ACC_W'(b);

endmodule

// File: rtl/matrix_mul_seq_ctrl.sv
// Sequential matrix multiplier: one shared MAC stepping i/j/k, with a
// start/busy/done handshake and bus packing identical to the combinational unit.
module matrix_mul_seq_ctrl
    import matrix_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DIM_W-1:0]   a_m,
    input  logic [DIM_W-1:0]   a_n,
    input  logic [DIM_W-1:0]   b_m,
    input  logic [DIM_W-1:0]   b_n,
    input  logic [A_BUS_W-1:0] matrixA,
    input  logic [A_BUS_W-1:0] matrixB,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic               mulError,
    output logic [DIM_W-1:0]   c_m,
    output logic [DIM_W-1:0]   c_n,
    output logic [C_BUS_W-1:0] aMulB
);

    state_t             state;
    logic [DIM_W-1:0]   a_rows, a_cols, b_rows, b_cols;
    logic [A_BUS_W-1:0] mat_a, mat_b;
    logic [DIM_W-1:0]   row_idx, col_idx, k_idx;
    logic [ACC_W-1:0]   acc;
    logic [ELEM_W-1:0]  a_elem, b_elem;
    logic [ACC_W-1:0]   mac_sum;
    logic               dim_error;

    always_comb begin
        a_elem    = mat_a[elem_a_lsb(row_idx, k_idx) +: ELEM_W];
        b_elem    = mat_b[elem_a_lsb(k_idx, col_idx) +: ELEM_W];
        dim_error = (a_rows == '0) || (a_cols == '0) || (b_rows == '0) || (b_cols == '0) ||
                    (a_rows > DIM_W'(DIM_MAX)) || (a_cols > DIM_W'(DIM_MAX)) ||
                    (b_rows > DIM_W'(DIM_MAX)) || (b_cols > DIM_W'(DIM_MAX)) ||
                    (a_cols != b_rows);
    end

    matrix_elem_mac u_mac (
        .a   (a_elem),
        .b   (b_elem),
        .acc (acc),
        .sum (mac_sum)
    );

    // Operands are captured at acceptance so the caller may change its inputs mid-run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            mulError <= 1'b0;
            c_m      <= '0;
            c_n      <= '0;
            aMulB    <= '0;
            a_rows   <= '0;
            a_cols   <= '0;
            b_rows   <= '0;
            b_cols   <= '0;
            mat_a    <= '0;
            mat_b    <= '0;
            row_idx  <= '0;
            col_idx  <= '0;
            k_idx    <= '0;
            acc      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_rows   <= a_m;
                        a_cols   <= a_n;
                        b_rows   <= b_m;
                        b_cols   <= b_n;
                        mat_a    <= matrixA;
                        mat_b    <= matrixB;
                        valid    <= 1'b0;
                        mulError <= 1'b0;
                        c_m      <= '0;
                        c_n      <= '0;
                        aMulB    <= '0;
                        busy     <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (dim_error) begin
                        mulError <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        row_idx <= '0;
                        col_idx <= '0;
                        k_idx   <= '0;
                        acc     <= '0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    if (k_idx < a_cols - 3'd1) begin
                        acc   <= mac_sum;
                        k_idx <= k_idx + 3'd1;
                    end else begin
                        aMulB[elem_c_lsb(row_idx, col_idx) +: ACC_W] <= mac_sum;
                        acc   <= '0;
                        k_idx <= '0;
                        if (col_idx < b_cols - 3'd1) begin
                            col_idx <= col_idx + 3'd1;
                        end else if (row_idx < a_rows - 3'd1) begin
                            col_idx <= '0;
                            row_idx <= row_idx + 3'd1;
                        end else begin
                            valid <= 1'b1;
                            c_m   <= a_rows;
                            c_n   <= b_cols;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
